// File: rtl/c_sample_filter_if.sv
// Bundles the sampled-level inputs and the filtered status outputs of c_sample_filter.
interface c_sample_filter_if #(
   parameter int CNT_W = 8
);
   logic             pi_c;
   logic             pi_flag16;
   logic             pi_clr;
   logic             po_level;
   logic             po_rise;
   logic             po_fall;
   logic [CNT_W-1:0] po_cnt;
   logic [1:0]       po_state;

   modport master (
      output pi_c, pi_flag16, pi_clr,
      input  po_level, po_rise, po_fall, po_cnt, po_state
   );

   modport slave (
      input  pi_c, pi_flag16, pi_clr,
      output po_level, po_rise, po_fall, po_cnt, po_state
   );
endinterface

// File: rtl/c_sample_filter.sv
// Strobe-gated debouncer for the a_and_b level: filtered level, edge pulses and a
// saturating rising-event counter.
module c_sample_filter #(
   parameter int DEB_N = 4,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   c_sample_filter_if.slave bus
);
   localparam int RW = $clog2(DEB_N + 1);

   typedef enum logic [1:0] {LOW = 2'd0, RISE = 2'd1, HIGH = 2'd2, FALL = 2'd3} state_t;

   state_t           state;
   logic [RW-1:0]    run;
   logic [RW-1:0]    run_nxt;
   logic             run_done;
   logic             level;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] cnt;

   assign run_nxt  = run + RW'(1);
   assign run_done = (run_nxt == RW'(DEB_N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOW;
         run   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         cnt   <= '0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (bus.pi_clr) cnt <= '0;
         // Every strobe-high cycle is one sample; pi_c is don't-care otherwise.
         if (bus.pi_flag16) begin
            case (state)
               LOW: begin
                  if (bus.pi_c) begin
                     state <= RISE;
                     run   <= RW'(1);
                  end
               end
               RISE: begin
                  if (!bus.pi_c) begin
                     state <= LOW;
                     run   <= '0;
                  end else if (run_done) begin
                     state <= HIGH;
                     run   <= '0;
                     level <= 1'b1;
                     rise  <= 1'b1;
                     // A coincident clear drops this event from the count.
                     if (!bus.pi_clr && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                  end else begin
                     run <= run_nxt;
                  end
               end
               HIGH: begin
                  if (!bus.pi_c) begin
                     state <= FALL;
                     run   <= RW'(1);
                  end
               end
               FALL: begin
                  if (bus.pi_c) begin
                     state <= HIGH;
                     run   <= '0;
                  end else if (run_done) begin
                     state <= LOW;
                     run   <= '0;
                     level <= 1'b0;
                     fall  <= 1'b1;
                  end else begin
                     run <= run_nxt;
                  end
               end
               default: begin
                  state <= LOW;
                  run   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.po_level = level;
   assign bus.po_rise  = rise;
   assign bus.po_fall  = fall;
   assign bus.po_cnt   = cnt;
   assign bus.po_state = state;
endmodule

// File: tb/tb_c_sample_filter.sv
// Directed bench for c_sample_filter (DEB_N=4, CNT_W=3) with an expected-output queue.
module tb_c_sample_filter;
   localparam int DEB  = 4;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic          level;
      logic          rise;
      logic          fall;
      logic [CW-1:0] cnt;
      logic [1:0]    state;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   exp_t sb[$];

   int m_state, m_run, m_level, m_cnt;

   c_sample_filter_if #(.CNT_W(CW)) bus ();

   c_sample_filter #(.DEB_N(DEB), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one clk cycle; predict outputs after the edge, then compare.
   task automatic step(input logic c, input logic f, input logic clr);
      exp_t e;
      exp_t o;
      bit   r = 0;
      bit   fl = 0;
      bus.pi_c      = c;
      bus.pi_flag16 = f;
      bus.pi_clr    = clr;
      if (clr) m_cnt = 0;
      if (f) begin
         case (m_state)
            0: if (c) begin m_state = 1; m_run = 1; end
            1: if (!c) begin m_state = 0; m_run = 0; end
               else if (m_run + 1 == DEB) begin
                  m_state = 2; m_run = 0; m_level = 1; r = 1;
                  if (!clr && m_cnt < CMAX) m_cnt = m_cnt + 1;
               end else m_run = m_run + 1;
            2: if (!c) begin m_state = 3; m_run = 1; end
            default: if (c) begin m_state = 2; m_run = 0; end
               else if (m_run + 1 == DEB) begin
                  m_state = 0; m_run = 0; m_level = 0; fl = 1;
               end else m_run = m_run + 1;
         endcase
      end
      e.level = m_level[0]; e.rise = r; e.fall = fl;
      e.cnt = CW'(m_cnt); e.state = 2'(m_state);
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("level", 8'(bus.po_level), 8'(o.level));
      chk("rise",  8'(bus.po_rise),  8'(o.rise));
      chk("fall",  8'(bus.po_fall),  8'(o.fall));
      chk("cnt",   8'(bus.po_cnt),   8'(o.cnt));
      chk("state", 8'(bus.po_state), 8'(o.state));
      chk("no_both_pulses", 8'(bus.po_rise & bus.po_fall), 8'd0);
   endtask

   // 15 idle cycles with a glitching pi_c, then one strobe cycle.
   task automatic strobe(input logic c, input logic clr);
      for (int i = 0; i < 15; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(c, 1'b1, clr);
   endtask

   initial begin
      tests = 0; fails = 0;
      m_state = 0; m_run = 0; m_level = 0; m_cnt = 0;
      rst_n = 1'b0;
      bus.pi_c = 1'b0; bus.pi_flag16 = 1'b0; bus.pi_clr = 1'b0;
      #3;
      chk("rst_level", 8'(bus.po_level), 8'd0);
      chk("rst_cnt",   8'(bus.po_cnt),   8'd0);
      chk("rst_state", 8'(bus.po_state), 8'd0);
      chk("rst_pulse", 8'(bus.po_rise | bus.po_fall), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clean rise on the 4th strobe
      strobe(1'b1, 1'b0);
      chk("first_strobe_state", 8'(bus.po_state), 8'd1);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      chk("clean_rise", 8'(bus.po_rise), 8'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("rise_one_clk", 8'(bus.po_rise), 8'd0);
      chk("clean_cnt", 8'(bus.po_cnt), 8'd1);

      // Back to LOW and clear, then bounce 1,1,0,1,1,1,1
      for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
      chk("bounce_low", 8'(bus.po_state), 8'd0);
      for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
      chk("bounce_rise", 8'(bus.po_rise), 8'd1);
      chk("bounce_cnt", 8'(bus.po_cnt), 8'd1);

      // Aborted fall, then a real fall
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b0);
      chk("fall_abort_state", 8'(bus.po_state), 8'd2);
      for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0);
      chk("fall_pulse", 8'(bus.po_fall), 8'd1);
      chk("fall_cnt", 8'(bus.po_cnt), 8'd1);

      // Saturation at 7, clear, clear coincident with a rise
      for (int k = 0; k < 9; k++) begin
         for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
         for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0);
      end
      chk("sat_cnt", 8'(bus.po_cnt), 8'd7);
      step(1'b0, 1'b0, 1'b1);
      chk("clr_cnt", 8'(bus.po_cnt), 8'd0);
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b1);
      chk("clr_rise_pulse", 8'(bus.po_rise), 8'd1);
      chk("clr_rise_cnt", 8'(bus.po_cnt), 8'd0);
      for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0);

      // Strobe gating, then back-to-back strobes
      for (int i = 0; i < 100; i++) step(1'(i & 1), 1'b0, 1'b0);
      chk("gated_state", 8'(bus.po_state), 8'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
      chk("b2b_rise", 8'(bus.po_rise), 8'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);

      // Reset mid-debounce (RISE, run=3)
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      chk("pre_rst_state", 8'(bus.po_state), 8'd1);
      rst_n = 1'b0;
      #1;
      m_state = 0; m_run = 0; m_level = 0; m_cnt = 0;
      chk("async_rst_state", 8'(bus.po_state), 8'd0);
      chk("async_rst_cnt", 8'(bus.po_cnt), 8'd0);
      chk("async_rst_level", 8'(bus.po_level), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      chk("post_rst_no_rise", 8'(bus.po_level), 8'd0);
      strobe(1'b1, 1'b0);
      chk("post_rst_rise", 8'(bus.po_rise), 8'd1);
      chk("post_rst_cnt", 8'(bus.po_cnt), 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/c_sample_filter.md
Name: c_sample_filter

Overview:
- Downstream consumer of the strobed AND output (po_c of the a_and_b stage).
- Debounces the sampled level using the same flag16 strobe that clocks the a_and_b sampling, so it looks at one sample per strobe period.
- Produces a clean filtered level, single-cycle rise/fall event pulses and a saturating rising-event counter for status readout.

Parameters:
DEB_N, 4, consecutive agreeing strobe samples required to change the filtered level; legal range 2..255
CNT_W, 8, width of the rising-event counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pi_c  input  1  sampled level from the a_and_b stage, already synchronous to clk
pi_flag16  input  1  sample strobe (flag16); pi_c is evaluated only in cycles where this is 1
pi_clr  input  1  synchronous clear of the event counter
po_level  output  1  debounced level
po_rise  output  1  one-cycle pulse when po_level goes 0->1
po_fall  output  1  one-cycle pulse when po_level goes 1->0
po_cnt  output  CNT_W  count of rising events, saturating
po_state  output  2  FSM state for debug: 0 LOW, 1 RISE, 2 HIGH, 3 FALL

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values:
  - state = LOW; internal run counter = 0.
  - po_level = 0, po_rise = 0, po_fall = 0, po_cnt = 0, po_state = 0.
- Sample cycle = a clk cycle with pi_flag16 = 1.
  - In cycles with pi_flag16 = 0, state and run counter hold.
  - po_rise and po_fall return to 0.
- If pi_flag16 stays high for several cycles, each cycle is a separate sample. No edge detection on the strobe.
- Run counter width is ceil(log2(DEB_N+1)).
- FSM on sample cycles:
  - LOW:
    - pi_c = 1 -> RISE, run = 1.
    - pi_c = 0 -> stay LOW.
  - RISE:
    - pi_c = 1 and run+1 == DEB_N -> HIGH, run = 0, po_level = 1, po_rise = 1, po_cnt increments.
    - pi_c = 1 otherwise -> run increments.
    - pi_c = 0 -> LOW, run = 0, no pulse.
  - HIGH:
    - pi_c = 0 -> FALL, run = 1.
    - pi_c = 1 -> stay HIGH.
  - FALL:
    - pi_c = 0 and run+1 == DEB_N -> LOW, run = 0, po_level = 0, po_fall = 1.
    - pi_c = 0 otherwise -> run increments.
    - pi_c = 1 -> HIGH, run = 0, no pulse.
- Latency:
  - po_level and po_rise/po_fall change on the clk edge ending the DEB_N-th agreeing sample cycle.
  - po_rise/po_fall are exactly 1 clk wide.
  - po_rise and po_fall are never high together.
- po_cnt:
  - Increments by 1 per po_rise.
  - Saturates at 2^CNT_W-1 and does not wrap.
- pi_clr:
  - Sets po_cnt = 0 on the next edge. FSM and level are unaffected.
  - pi_clr in the same cycle as a rise event: clear wins, po_cnt = 0, and the event is dropped from the count. po_rise still pulses.
- po_state mirrors the state register.
- Reset mid-debounce: async return to reset values immediately; a partial run is discarded.
- pi_c is ignored in non-sample cycles, including glitches between strobes.

Test Plan:
- Reset, then strobe every 16 clk with pi_c = 1 held (DEB_N = 4):
  - po_state goes 1 after strobe 1.
  - po_level = 1 and a 1-clk po_rise after the 4th strobe edge.
  - po_cnt = 1.
- Bounce: pi_c pattern 1,1,0,1,1,1,1 on successive strobes:
  - Returns to LOW after the 3rd sample.
  - po_rise only after the 7th sample.
  - po_cnt = 1.
- Fall path: from HIGH, pi_c = 0 for 3 strobes then 1:
  - Back to HIGH, no po_fall.
  - Then 4 zeros -> po_fall pulse, po_level = 0, po_cnt unchanged.
- Saturation with CNT_W = 3:
  - 9 clean high/low cycles give po_cnt = 7.
  - Then pi_clr -> 0.
  - pi_clr coincident with a rise event -> po_cnt = 0 and po_rise = 1.
- Strobe gating: toggle pi_c every clk with pi_flag16 = 0 for 100 clk -> no state change. Then hold pi_flag16 = 1 with pi_c = 1 for 4 consecutive clk -> po_rise on the 4th edge.
- Assert rst_n = 0 while in RISE with run = 3 -> outputs and state 0 immediately. After release, 4 fresh samples are needed to rise.
